// File: rtl/l1_dcache_pkg.sv
// Shared definitions for the L1 data cache: geometry, FSM state encoding and word extraction.
package l1_dcache_pkg;

  localparam int BLOCK_BITS      = 128;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_ADDR_BITS = 16;
  localparam int OFFSET_BITS     = 4;
  localparam int CPU_ADDR_BITS   = BLOCK_ADDR_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  function automatic logic [WORD_BITS-1:0] line_word(input logic [BLOCK_BITS-1:0] line,
                                                     input logic [1:0] sel);
    return line[WORD_BITS*sel +: WORD_BITS];
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Direct-mapped storage: valid/dirty bits (async cleared) plus tag and line arrays (never cleared).
module l1_dcache_array
  import l1_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = BLOCK_ADDR_BITS - INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_line,
  input  logic                  word_we,
  input  logic [1:0]            word_sel,
  input  logic [WORD_BITS-1:0]  word_data,
  input  logic                  fill_we,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [BLOCK_BITS-1:0] fill_line,
  input  logic                  clr_dirty
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [SETS-1:0]       dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [BLOCK_BITS-1:0] data_q [SETS];
  logic [BLOCK_BITS-1:0] line_d;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // A fill wins over a word store; the store merges one word into the current line.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_d  = rd_line;
    if (fill_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      line_d       = fill_line;
    end else if (word_we) begin
      dirty_d[idx] = 1'b1;
      line_d[WORD_BITS*word_sel +: WORD_BITS] = word_data;
    end else if (clr_dirty) begin
      dirty_d[idx] = 1'b0;
    end else begin
      line_d = rd_line;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we || word_we) begin
      data_q[idx] <= line_d;
    end
    if (fill_we) begin
      tag_q[idx] <= fill_tag;
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 D-cache controller: zero-latency hits,
// misses become an optional 128-bit writeback followed by a refill on the Dmem port.
module l1_dcache_ctrl
  import l1_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_ren,
  input  logic                       cpu_wen,
  input  logic [CPU_ADDR_BITS-1:0]   cpu_addr,
  input  logic [WORD_BITS-1:0]       cpu_wdata,
  output logic [WORD_BITS-1:0]       cpu_rdata,
  output logic                       cpu_stall,
  output logic                       mem_ren,
  output logic                       mem_wen,
  output logic [BLOCK_ADDR_BITS-1:0] mem_block_address,
  output logic [BLOCK_BITS-1:0]      mem_din,
  input  logic [BLOCK_BITS-1:0]      mem_dout,
  input  logic                       mem_ready,
  input  logic                       mem_done
);

  localparam int TAG_BITS = BLOCK_ADDR_BITS - INDEX_BITS;

  state_e                     state_q, state_d;
  logic                       mem_ren_q, mem_ren_d;
  logic                       mem_wen_q, mem_wen_d;
  logic [BLOCK_ADDR_BITS-1:0] addr_q, addr_d;
  logic [BLOCK_BITS-1:0]      din_q, din_d;

  logic [INDEX_BITS-1:0]      idx_s;
  logic [TAG_BITS-1:0]        tag_s, rd_tag_s;
  logic [BLOCK_ADDR_BITS-1:0] blk_addr_s, victim_addr_s;
  logic [BLOCK_BITS-1:0]      rd_line_s;
  logic                       rd_valid_s, rd_dirty_s, hit_s, req_s, miss_s;
  logic                       word_we_s, fill_we_s, clr_dirty_s;
  logic                       unused_s;

  assign blk_addr_s    = cpu_addr[CPU_ADDR_BITS-1:OFFSET_BITS];
  assign idx_s         = blk_addr_s[INDEX_BITS-1:0];
  assign tag_s         = blk_addr_s[BLOCK_ADDR_BITS-1:INDEX_BITS];
  assign victim_addr_s = {rd_tag_s, idx_s};
  assign req_s         = cpu_ren | cpu_wen;
  assign hit_s         = rd_valid_s && (rd_tag_s == tag_s);
  assign miss_s        = req_s && !hit_s;
  assign word_we_s     = (state_q == ST_IDLE) && cpu_wen && hit_s;
  assign unused_s      = ^cpu_addr[1:0];

  l1_dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .idx       (idx_s),
    .rd_valid  (rd_valid_s),
    .rd_dirty  (rd_dirty_s),
    .rd_tag    (rd_tag_s),
    .rd_line   (rd_line_s),
    .word_we   (word_we_s),
    .word_sel  (cpu_addr[3:2]),
    .word_data (cpu_wdata),
    .fill_we   (fill_we_s),
    .fill_tag  (tag_s),
    .fill_line (mem_dout),
    .clr_dirty (clr_dirty_s)
  );

  // Loads return data only on a clean IDLE hit; a simultaneous store takes priority.
  always_comb begin
    cpu_stall = (state_q != ST_IDLE) || miss_s;
    if ((state_q == ST_IDLE) && cpu_ren && !cpu_wen && hit_s) begin
      cpu_rdata = line_word(rd_line_s, cpu_addr[3:2]);
    end else begin
      cpu_rdata = {WORD_BITS{1'b0}};
    end
  end

  // Requests rise only while Dmem is ready and, once up, hold address/data until mem_done.
  always_comb begin
    state_d     = state_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    addr_d      = addr_q;
    din_d       = din_q;
    fill_we_s   = 1'b0;
    clr_dirty_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_s && rd_valid_s && rd_dirty_s) begin
          state_d   = ST_WRITEBACK;
          mem_wen_d = mem_ready;
          addr_d    = victim_addr_s;
          din_d     = rd_line_s;
        end else if (miss_s) begin
          state_d   = ST_REFILL;
          mem_ren_d = mem_ready;
          addr_d    = blk_addr_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_wen_q && mem_done) begin
          mem_wen_d   = 1'b0;
          clr_dirty_s = 1'b1;
          state_d     = ST_REFILL;
        end else if (!mem_wen_q) begin
          mem_wen_d = mem_ready;
          addr_d    = victim_addr_s;
          din_d     = rd_line_s;
        end else begin
          mem_wen_d = 1'b1;
        end
      end
      ST_REFILL: begin
        if (mem_ren_q && mem_done) begin
          mem_ren_d = 1'b0;
          fill_we_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (!mem_ren_q) begin
          mem_ren_d = mem_ready;
          addr_d    = blk_addr_s;
        end else begin
          mem_ren_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // Controller state and Dmem request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      addr_q    <= {BLOCK_ADDR_BITS{1'b0}};
      din_q     <= {BLOCK_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign mem_ren           = mem_ren_q;
  assign mem_wen           = mem_wen_q;
  assign mem_block_address = addr_q;
  assign mem_din           = din_q;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl with a 10-cycle Dmem model driven on the falling edge.
module tb_l1_dcache_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_ren, cpu_wen;
  logic [19:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_ren, mem_wen;
  logic [15:0]  mem_block_address;
  logic [127:0] mem_din, mem_dout;
  logic         mem_ready, mem_done;
  logic         done_m, stray_done;

  int err_cnt = 0;
  int chk_cnt = 0;
  int rd_reqs = 0;
  int wr_reqs = 0;
  int busy_cnt = 0;
  logic busy = 1'b0;
  int lat;

  assign mem_ready = !busy;
  assign mem_done  = done_m | stray_done;

  l1_dcache_ctrl #(.INDEX_BITS(5)) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_ren           (cpu_ren),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .mem_ren           (mem_ren),
    .mem_wen           (mem_wen),
    .mem_block_address (mem_block_address),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_ready         (mem_ready),
    .mem_done          (mem_done)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] dmem_line(input logic [15:0] ba);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = {ba, 16'(i)};
    if (ba == 16'h0001) l[63:32] = 32'hA5A5A5A5;
    return l;
  endfunction

  // Dmem model: accepts a request, answers with a one-cycle mem_done 10 cycles later.
  always @(negedge clock) begin
    done_m = 1'b0;
    if (!reset) begin
      busy = 1'b0;
    end else if (busy) begin
      if (busy_cnt == 1) begin
        done_m   = 1'b1;
        mem_dout = dmem_line(mem_block_address);
        busy     = 1'b0;
      end else begin
        busy_cnt = busy_cnt - 1;
      end
    end else if (mem_ren || mem_wen) begin
      busy     = 1'b1;
      busy_cnt = 10;
      if (mem_ren) rd_reqs++;
      if (mem_wen) wr_reqs++;
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_unstall(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      cycles++;
      if (!cpu_stall) break;
    end
    check_val({tag, "_unstall"}, cpu_stall, 0);
  endtask

  task automatic wait_mem_ren(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (mem_ren) break;
    end
    check_val({tag, "_mem_ren"}, mem_ren, 1);
  endtask

  initial begin
    reset = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
    cpu_addr = 20'h0; cpu_wdata = 32'h0; mem_dout = 128'h0;
    done_m = 1'b0; stray_done = 1'b0;
    repeat (3) step();
    check_val("rst_stall", cpu_stall, 0);
    check_val("rst_mem_ren", mem_ren, 0);
    check_val("rst_mem_wen", mem_wen, 0);
    check_val("rst_addr", mem_block_address, 16'h0000);
    check_val("rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b1;
    step();

    // 1: clean read miss then refill
    cpu_ren = 1'b1; cpu_addr = 20'h00014; #1;
    check_val("t1_stall", cpu_stall, 1);
    step();
    check_val("t1_mem_ren", mem_ren, 1);
    check_val("t1_addr", mem_block_address, 16'h0001);
    wait_unstall("t1", lat);
    check_val("t1_latency", lat, 11);
    check_val("t1_rdata", cpu_rdata, 32'hA5A5A5A5);

    // 2: hit on the same line
    cpu_addr = 20'h00018; #1;
    check_val("t2_stall", cpu_stall, 0);
    check_val("t2_rdata", cpu_rdata, 32'h00010002);
    step();
    check_val("t2_no_mem_ren", mem_ren, 0);
    check_val("t2_rd_reqs", rd_reqs, 1);

    // 3: write hit, then conflicting miss forces writeback
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 20'h00014; cpu_wdata = 32'hDEADBEEF; #1;
    check_val("t3_wr_stall", cpu_stall, 0);
    step();
    cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_addr = 20'h00214; #1;
    check_val("t3_miss_stall", cpu_stall, 1);
    check_val("t3_no_wr_traffic", wr_reqs, 0);
    step();
    check_val("t3_mem_wen", mem_wen, 1);
    check_val("t3_mem_ren_off", mem_ren, 0);
    check_val("t3_wb_addr", mem_block_address, 16'h0001);
    check_val("t3_wb_w1", mem_din[63:32], 32'hDEADBEEF);
    check_val("t3_wb_w0", mem_din[31:0], 32'h00010000);
    wait_mem_ren("t3");
    check_val("t3_rf_wen_off", mem_wen, 0);
    check_val("t3_rf_addr", mem_block_address, 16'h0021);
    wait_unstall("t3", lat);
    check_val("t3_rdata", cpu_rdata, 32'h00210001);

    // 4: write miss on clean index 3
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 32'h12345678; #1;
    check_val("t4_stall", cpu_stall, 1);
    step();
    check_val("t4_mem_ren", mem_ren, 1);
    check_val("t4_mem_wen", mem_wen, 0);
    check_val("t4_addr", mem_block_address, 16'h0003);
    wait_unstall("t4", lat);
    step();
    cpu_wen = 1'b0; cpu_ren = 1'b1; #1;
    check_val("t4_stall_rd", cpu_stall, 0);
    check_val("t4_rdata", cpu_rdata, 32'h12345678);
    check_val("t4_wr_reqs", wr_reqs, 1);

    // 5: ren and wen together act as a store and dirty a clean line
    cpu_wen = 1'b1; cpu_addr = 20'h00218; cpu_wdata = 32'hCAFEF00D; #1;
    check_val("t5_stall", cpu_stall, 0);
    step();
    cpu_wen = 1'b0; #1;
    check_val("t5_rdata", cpu_rdata, 32'hCAFEF00D);
    cpu_addr = 20'h00018; #1;
    step();
    check_val("t5_dirty_wb", mem_wen, 1);
    check_val("t5_wb_addr", mem_block_address, 16'h0021);
    check_val("t5_wb_w2", mem_din[95:64], 32'hCAFEF00D);
    wait_unstall("t5", lat);
    check_val("t5_rdata2", cpu_rdata, 32'h00010002);

    // 6: reset during refill, stray mem_done in IDLE, re-read misses again
    cpu_addr = 20'h00040; #1;
    step();
    check_val("t6_mem_ren", mem_ren, 1);
    repeat (3) step();
    reset = 1'b0; #1;
    check_val("t6_rst_mem_ren", mem_ren, 0);
    check_val("t6_rst_addr", mem_block_address, 16'h0000);
    cpu_ren = 1'b0;
    step();
    reset = 1'b1;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0; #1;
    check_val("t6_stray_ren", mem_ren, 0);
    check_val("t6_stray_wen", mem_wen, 0);
    check_val("t6_stray_stall", cpu_stall, 0);
    cpu_ren = 1'b1; cpu_addr = 20'h00040; #1;
    check_val("t6_remiss", cpu_stall, 1);
    step();
    check_val("t6_re_mem_ren", mem_ren, 1);
    wait_unstall("t6", lat);
    check_val("t6_rdata", cpu_rdata, 32'h00040000);
    cpu_ren = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
